pipelined_adder_subtractor: RTL and testbench

Parametrised, pipelined successor to the combinational adder/subtractor. It splits a DATA_WIDTH operand into STAGES equal chunks and ripples the carry through one register stage per chunk. Throughput is one operation per cycle, with a valid/ready handshake on both sides and a global stall. It adds signed-overflow and zero flags, and is the arithmetic unit for wide-datapath blocks that cannot close timing with a single-cycle carry chain.

---
 rtl/pipelined_adder_subtractor.sv | 131 +++++++++++++
 tb/tb_pipelined_adder_subtractor.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder_subtractor.sv
// Pipelined adder/subtractor: the carry ripples through one register stage per operand chunk.
// Valid/ready on both sides; a single global enable freezes the whole pipe under backpressure.
module pipelined_adder_subtractor #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STAGES     = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic                  CI,
    input  logic                  SUB,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [DATA_WIDTH-1:0] S,
    output logic                  CO,
    output logic                  OV,
    output logic                  Z
);

    localparam int CHUNK = int'(DATA_WIDTH / STAGES);
    localparam int CW    = CHUNK + 1;
    localparam int ST    = int'(STAGES);
    localparam int NREG  = (ST > 1) ? ST - 1 : 1;

    // acc holds finished result chunks below the current stage and untouched A chunks above it;
    // b holds the remaining (already inverted for subtract) B chunks, current chunk in the LSBs.
    typedef struct packed {
        logic                  vld;
        logic                  sub;
        logic                  cy;
        logic                  z;
        logic [DATA_WIDTH-1:0] acc;
        logic [DATA_WIDTH-1:0] b;
    } stage_t;

    stage_t stage_q [NREG];
    stage_t stage_d [NREG];

    logic                  out_vld_q, out_vld_d;
    logic [DATA_WIDTH-1:0] s_q, s_d;
    logic                  co_q, co_d;
    logic                  ov_q, ov_d;
    logic                  z_q, z_d;

    logic                  en;
    stage_t                cur, nxt;
    logic [CHUNK:0]        add;
    logic                  a_sign, b_sign;

    assign en = !out_vld_q || OUT_READY;

    always_comb begin
        stage_d   = stage_q;
        out_vld_d = out_vld_q;
        s_d       = s_q;
        co_d      = co_q;
        ov_d      = ov_q;
        z_d       = z_q;

        cur.vld = IN_VALID;
        cur.sub = SUB;
        cur.cy  = CI ^ SUB;
        cur.z   = 1'b1;
        cur.acc = A;
        cur.b   = SUB ? ~B : B;

        nxt    = cur;
        add    = '0;
        a_sign = 1'b0;
        b_sign = 1'b0;

        for (int k = 0; k < ST; k++) begin
            a_sign  = cur.acc[DATA_WIDTH-1];
            b_sign  = cur.b[CHUNK-1];
            add     = {1'b0, cur.acc[k*CHUNK +: CHUNK]} + {1'b0, cur.b[CHUNK-1:0]} + CW'(cur.cy);
            nxt     = cur;
            nxt.acc[k*CHUNK +: CHUNK] = add[CHUNK-1:0];
            nxt.b   = cur.b >> CHUNK;
            nxt.cy  = add[CHUNK];
            nxt.z   = cur.z & (add[CHUNK-1:0] == '0);
            if (k < ST - 1) begin
                if (en) begin
                    stage_d[k] = nxt;
                end
                cur = stage_q[k];
            end
        end

        // After the loop nxt/add/a_sign/b_sign describe the final stage.
        if (en) begin
            out_vld_d = nxt.vld;
            if (nxt.vld) begin
                s_d  = nxt.acc;
                co_d = nxt.cy ^ nxt.sub;
                ov_d = (a_sign == b_sign) && (add[CHUNK-1] != a_sign);
                z_d  = nxt.z;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NREG; i++) begin
                stage_q[i] <= '0;
            end
            out_vld_q <= 1'b0;
            s_q       <= '0;
            co_q      <= 1'b0;
            ov_q      <= 1'b0;
            z_q       <= 1'b0;
        end else begin
            stage_q   <= stage_d;
            out_vld_q <= out_vld_d;
            s_q       <= s_d;
            co_q      <= co_d;
            ov_q      <= ov_d;
            z_q       <= z_d;
        end
    end

    assign IN_READY  = en;
    assign OUT_VALID = out_vld_q;
    assign S         = s_q;
    assign CO        = co_q;
    assign OV        = ov_q;
    assign Z         = z_q;

endmodule

// File: tb/tb_pipelined_adder_subtractor.sv
// Bench for pipelined_adder_subtractor: directed arithmetic corners, random streaming,
// random backpressure and mid-flight reset, checked against an arithmetic delay-line model.
module tb_pipelined_adder_subtractor;

    localparam int W  = 32;
    localparam int ST = 4;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         IN_VALID = 1'b0;
    logic         IN_READY;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         CI = 1'b0;
    logic         SUB = 1'b0;
    logic         OUT_VALID;
    logic         OUT_READY = 1'b1;
    logic [W-1:0] S;
    logic         CO, OV, Z;

    pipelined_adder_subtractor #(
        .DATA_WIDTH(W),
        .STAGES    (ST)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .A        (A),
        .B        (B),
        .CI       (CI),
        .SUB      (SUB),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .S        (S),
        .CO       (CO),
        .OV       (OV),
        .Z        (Z)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        logic         z;
    } res_t;

    int   total = 0;
    int   bad   = 0;
    bit   known = 1'b0;
    bit   pv [ST];
    res_t pr [ST];
    res_t held;

    localparam longint MAXS = 64'sh7FFF_FFFF;
    localparam longint MINS = -64'sh8000_0000;

    // Plain integer arithmetic reference of one operation.
    function automatic res_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic ci, input logic sub);
        res_t            r;
        longint unsigned ua, ub, uc;
        longint          sa, sb, sr;
        ua = longint'(a);
        ub = longint'(b);
        uc = longint'(ci);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            r.s  = W'(ua - ub - uc);
            r.co = (ua < ub + uc);
            sr   = sa - sb - longint'(uc);
        end else begin
            r.s  = W'(ua + ub + uc);
            r.co = (ua + ub + uc) > 64'hFFFF_FFFF;
            sr   = sa + sb + longint'(uc);
        end
        r.ov = (sr > MAXS) || (sr < MINS);
        r.z  = (r.s == '0);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < ST; i++) begin
            pv[i] = 1'b0;
            pr[i] = '0;
        end
        held = '0;
    endtask

    // One clock: drive inputs, check IN_READY, clock, advance the model, check outputs.
    task automatic cycle(input logic rst, input logic iv, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic ci, input logic sub,
                         input logic ordy);
        logic mv, en;
        RST = rst; IN_VALID = iv; A = a; B = b; CI = ci; SUB = sub; OUT_READY = ordy;
        mv = pv[ST-1];
        en = !mv || ordy;
        #1;
        if (known) chk("in_ready", W'(IN_READY), W'(en));
        @(posedge CLK);
        if (rst) begin
            model_clear();
            known = 1'b1;
        end else if (en) begin
            for (int i = ST - 1; i > 0; i--) begin
                pv[i] = pv[i-1];
                pr[i] = pr[i-1];
            end
            pv[0] = iv;
            pr[0] = ref_op(a, b, ci, sub);
            if (pv[ST-1]) held = pr[ST-1];
        end
        #1;
        chk("out_valid", W'(OUT_VALID), W'(pv[ST-1]));
        chk("s", S, held.s);
        chk("co", W'(CO), W'(held.co));
        chk("ov", W'(OV), W'(held.ov));
        chk("z", W'(Z), W'(held.z));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    // Single operation into an empty pipe; result must appear exactly ST cycles later.
    task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic ci, input logic sub, input logic [W-1:0] es,
                            input logic eco, input logic eov, input logic ez);
        cycle(1'b0, 1'b1, a, b, ci, sub, 1'b1);
        idle(ST - 2);
        chk({tag, "_early"}, W'(OUT_VALID), W'(1'b0));
        idle(1);
        chk({tag, "_vld"}, W'(OUT_VALID), W'(1'b1));
        chk({tag, "_s"}, S, es);
        chk({tag, "_co"}, W'(CO), W'(eco));
        chk({tag, "_ov"}, W'(OV), W'(eov));
        chk({tag, "_z"}, W'(Z), W'(ez));
        idle(1);
    endtask

    initial begin
        model_clear();
        cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 32'd5, 32'd6, 1'b0, 1'b0, 1'b1);
        chk("rst_ready", W'(IN_READY), W'(1'b1));

        directed("add_ci0", 32'd100, 32'd16, 1'b0, 1'b0, 32'd116, 1'b0, 1'b0, 1'b0);
        directed("add_ci1", 32'd100, 32'd16, 1'b1, 1'b0, 32'd117, 1'b0, 1'b0, 1'b0);
        directed("add_wrap", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
        directed("add_ovp", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        directed("add_ovn", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1);
        directed("sub_ci0", 32'd100, 32'd16, 1'b0, 1'b1, 32'd84, 1'b0, 1'b0, 1'b0);
        directed("sub_ci1", 32'd100, 32'd16, 1'b1, 1'b1, 32'd83, 1'b0, 1'b0, 1'b0);
        directed("sub_zero", 32'd200, 32'd200, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b1);
        directed("sub_neg", 32'd8, 32'd12, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
        directed("sub_0m1", 32'd0, 32'd1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        directed("sub_ov", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);

        // Back-to-back streaming with the consumer always ready.
        for (int i = 0; i < 1000; i++) begin
            cycle(1'b0, 1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'b1);
        end
        idle(ST + 1);

        // Random bubbles and backpressure.
        for (int i = 0; i < 600; i++) begin
            cycle(1'b0, ($urandom_range(0, 3) != 0), $urandom, $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) != 0));
        end
        idle(ST + 2);

        // Reset with three operations in flight; IN_VALID high at the reset edge is ignored.
        cycle(1'b0, 1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 32'hFFFF_0000, 32'h0000_FFFF, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b1);
        chk("rst_vld", W'(OUT_VALID), W'(1'b0));
        chk("rst_s", S, 32'd0);
        chk("rst_co", W'(CO), W'(1'b0));
        idle(ST + 2);
        directed("post_rst", 32'd7, 32'd9, 1'b0, 1'b0, 32'd16, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
